bit_serializer: RTL and testbench

- Upstream feeder for the run-of-ones Mealy detector.
- Accepts parallel words over a valid/ready handshake and shifts them out one bit per enabled clock on dout, with cen qualifying each bit.
- Supports back-to-back words with no bubble, a programmable inter-word gap, and a hold input that freezes the bit stream.

---
 rtl/bit_serializer_pkg.sv | 12 +
 rtl/bit_serializer.sv | 119 +++++++++++
 tb/tb_bit_serializer.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/bit_serializer_pkg.sv
// rtl/bit_serializer_pkg.sv - shared state type and widths for the bit serializer
package bit_serializer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } ser_state_t;

    localparam int GAP_CNT_W = 4;

endpackage

// File: rtl/bit_serializer.sv
// rtl/bit_serializer.sv - parallel word to serial bit stream with gap and hold
module bit_serializer
    import bit_serializer_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int LSB_FIRST  = 0,
    parameter int GAP_CYCLES = 0
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    input  logic             hold,
    output logic             dout,
    output logic             cen,
    output logic             word_done
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0]     BIT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [GAP_CNT_W-1:0] GAP_LAST = GAP_CNT_W'(GAP_CYCLES - 1);

    ser_state_t           state_q;
    logic [WIDTH-1:0]     sh_q;
    logic [CNT_W-1:0]     bit_cnt_q;
    logic [GAP_CNT_W-1:0] gap_cnt_q;
    logic                 dout_q;
    logic                 cen_q;
    logic                 done_q;

    logic                 last_bit;
    logic                 gap_last;
    logic                 transfer;
    logic                 first_bit;
    logic [WIDTH-1:0]     sh_d;
    logic                 next_bit;
    logic [CNT_W-1:0]     bit_cnt_d;

    // Handshake and shift helpers; in_ready never looks at in_valid or in_data
    always_comb begin
        last_bit  = (bit_cnt_q == BIT_LAST);
        gap_last  = (gap_cnt_q == GAP_LAST);
        in_ready  = 1'b0;
        if (resetn) begin
            case (state_q)
                IDLE:    in_ready = 1'b1;
                SHIFT:   in_ready = !hold && last_bit && (GAP_CYCLES == 0);
                GAP:     in_ready = !hold && gap_last;
                default: in_ready = 1'b0;
            endcase
        end
        transfer  = in_valid && in_ready;
        first_bit = (LSB_FIRST != 0) ? in_data[0] : in_data[WIDTH-1];
        sh_d      = (LSB_FIRST != 0) ? (sh_q >> 1) : (sh_q << 1);
        next_bit  = (LSB_FIRST != 0) ? sh_d[0] : sh_d[WIDTH-1];
        bit_cnt_d = bit_cnt_q + CNT_W'(1);
    end

    // Sequencer: any accepted word loads directly, otherwise advance bits / gap
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q   <= IDLE;
            sh_q      <= '0;
            bit_cnt_q <= '0;
            gap_cnt_q <= '0;
            dout_q    <= 1'b0;
            cen_q     <= 1'b0;
            done_q    <= 1'b0;
        end else if (transfer) begin
            state_q   <= SHIFT;
            sh_q      <= in_data;
            bit_cnt_q <= '0;
            dout_q    <= first_bit;
            cen_q     <= 1'b1;
            done_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    dout_q <= 1'b0;
                    cen_q  <= 1'b0;
                    done_q <= 1'b0;
                end
                SHIFT: begin
                    if (!hold) begin
                        if (!last_bit) begin
                            bit_cnt_q <= bit_cnt_d;
                            sh_q      <= sh_d;
                            dout_q    <= next_bit;
                            done_q    <= (bit_cnt_d == BIT_LAST);
                        end else begin
                            state_q   <= (GAP_CYCLES > 0) ? GAP : IDLE;
                            gap_cnt_q <= '0;
                            dout_q    <= 1'b0;
                            cen_q     <= 1'b0;
                            done_q    <= 1'b0;
                        end
                    end
                end
                GAP: begin
                    if (!hold) begin
                        if (gap_last) begin
                            state_q <= IDLE;
                        end else begin
                            gap_cnt_q <= gap_cnt_q + GAP_CNT_W'(1);
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // A held cycle carries no bit: the registered bit stays, qualifiers drop
    assign dout      = dout_q;
    assign cen       = cen_q && !hold;
    assign word_done = done_q && !hold;

endmodule

// File: tb/tb_bit_serializer.sv
// tb/tb_bit_serializer.sv - table-driven bench for bit_serializer in three configurations
module tb_bit_serializer;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic [2:0] vi;
    logic [7:0] di [3];
    logic [2:0] hi;
    logic [2:0] rdy, dout_w, cen_w, done_w;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bit_serializer #(.WIDTH(8), .LSB_FIRST(0), .GAP_CYCLES(0)) u_msb (
        .clk(clk), .resetn(resetn), .in_valid(vi[0]), .in_data(di[0]),
        .in_ready(rdy[0]), .hold(hi[0]), .dout(dout_w[0]), .cen(cen_w[0]),
        .word_done(done_w[0]));

    bit_serializer #(.WIDTH(8), .LSB_FIRST(0), .GAP_CYCLES(2)) u_gap (
        .clk(clk), .resetn(resetn), .in_valid(vi[1]), .in_data(di[1]),
        .in_ready(rdy[1]), .hold(hi[1]), .dout(dout_w[1]), .cen(cen_w[1]),
        .word_done(done_w[1]));

    bit_serializer #(.WIDTH(8), .LSB_FIRST(1), .GAP_CYCLES(0)) u_lsb (
        .clk(clk), .resetn(resetn), .in_valid(vi[2]), .in_data(di[2]),
        .in_ready(rdy[2]), .hold(hi[2]), .dout(dout_w[2]), .cen(cen_w[2]),
        .word_done(done_w[2]));

    typedef struct {
        int       sel;
        bit       r;
        bit       v;
        bit [7:0] d;
        bit       h;
        bit       er;
        bit       ed;
        bit       ec;
        bit       ew;
        bit       dc;
    } vec_t;

    vec_t tv[$];

    task automatic add(input int sel, input bit r, input bit v, input bit [7:0] d,
                       input bit h, input bit er, input bit ed, input bit ec,
                       input bit ew, input bit dc);
        vec_t x;
        x.sel = sel; x.r = r; x.v = v; x.d = d; x.h = h;
        x.er = er; x.ed = ed; x.ec = ec; x.ew = ew; x.dc = dc;
        tv.push_back(x);
    endtask

    // Eight bit cycles of word w; on the last bit drive nv/nd and expect last_ready
    task automatic add_word(input int sel, input bit lsb, input bit [7:0] w,
                            input bit last_ready, input bit nv, input bit [7:0] nd);
        for (int i = 0; i < 8; i++) begin
            bit b;
            b = lsb ? w[i] : w[7-i];
            if (i == 7) add(sel, 1, nv, nd, 0, last_ready, b, 1, 1, 0);
            else        add(sel, 1, 0, 8'h00, 0, 0, b, 1, 0, 0);
        end
    endtask

    task automatic check(input string name, input bit [3:0] got, input bit [3:0] exp,
                         input bit [3:0] mask);
        checks++;
        if ((got & mask) !== (exp & mask)) begin
            errors++;
            $display("FAIL %s got rdy/dout/cen/done=%b expected=%b mask=%b",
                     name, got, exp, mask);
        end
    endtask

    initial begin
        bit [7:0] f0_bits;
        int       done_at;
        vi = '0; hi = '0;
        for (int k = 0; k < 3; k++) di[k] = 8'h00;

        // reset: first cycle outputs unknown, second must read all zero
        add(0, 0, 1, 8'h00, 0, 0, 0, 0, 0, 1);
        add(0, 0, 1, 8'h00, 0, 0, 0, 0, 0, 0);
        add(0, 1, 0, 8'h00, 0, 1, 0, 0, 0, 0);
        // single 0xE7
        add(0, 1, 1, 8'hE7, 0, 1, 0, 0, 0, 0);
        add_word(0, 0, 8'hE7, 1, 0, 8'h00);
        add(0, 1, 0, 8'h00, 0, 1, 0, 0, 0, 0);
        // back-to-back 0xFF, 0x00
        add(0, 1, 1, 8'hFF, 0, 1, 0, 0, 0, 0);
        add_word(0, 0, 8'hFF, 1, 1, 8'h00);
        add_word(0, 0, 8'h00, 1, 0, 8'h00);
        add(0, 1, 0, 8'h00, 0, 1, 0, 0, 0, 0);
        // 0xF0 with 3 hold cycles after the second bit
        f0_bits = 8'hF0;
        add(0, 1, 1, 8'hF0, 0, 1, 0, 0, 0, 0);
        add(0, 1, 0, 8'h00, 0, 0, 1, 1, 0, 0);
        add(0, 1, 0, 8'h00, 0, 0, 1, 1, 0, 0);
        for (int i = 0; i < 3; i++) add(0, 1, 0, 8'h00, 1, 0, 1, 0, 0, 0);
        for (int i = 2; i < 8; i++)
            add(0, 1, 0, 8'h00, 0, (i == 7), f0_bits[7-i], 1, (i == 7), 0);
        add(0, 1, 0, 8'h00, 0, 1, 0, 0, 0, 0);
        // 0x81 accepted under hold in IDLE, then hold over the last bit
        add(0, 1, 1, 8'h81, 1, 1, 0, 0, 0, 0);
        add(0, 1, 0, 8'h00, 0, 0, 1, 1, 0, 0);
        for (int i = 0; i < 6; i++) add(0, 1, 0, 8'h00, 0, 0, 0, 1, 0, 0);
        add(0, 1, 0, 8'h00, 1, 0, 1, 0, 0, 0);
        add(0, 1, 0, 8'h00, 0, 1, 1, 1, 1, 0);
        add(0, 1, 0, 8'h00, 0, 1, 0, 0, 0, 0);
        // 0xFF interrupted by reset after bit 4
        add(0, 1, 1, 8'hFF, 0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) add(0, 1, 0, 8'h00, 0, 0, 1, 1, 0, 0);
        add(0, 0, 0, 8'h00, 0, 0, 0, 0, 0, 1);
        add(0, 1, 0, 8'h00, 0, 1, 0, 0, 0, 0);
        add(0, 1, 0, 8'h00, 0, 1, 0, 0, 0, 0);
        // two-cycle gap: 0xA5 then 0x3C with valid held high
        add(1, 1, 1, 8'hA5, 0, 1, 0, 0, 0, 0);
        add_word(1, 0, 8'hA5, 0, 1, 8'h3C);
        add(1, 1, 1, 8'h3C, 0, 0, 0, 0, 0, 0);
        add(1, 1, 1, 8'h3C, 0, 1, 0, 0, 0, 0);
        add_word(1, 0, 8'h3C, 0, 0, 8'h00);
        add(1, 1, 0, 8'h00, 0, 0, 0, 0, 0, 0);
        add(1, 1, 0, 8'h00, 0, 1, 0, 0, 0, 0);
        add(1, 1, 0, 8'h00, 0, 1, 0, 0, 0, 0);
        // LSB first 0x01
        add(2, 1, 1, 8'h01, 0, 1, 0, 0, 0, 0);
        add_word(2, 1, 8'h01, 1, 0, 8'h00);
        add(2, 1, 0, 8'h00, 0, 1, 0, 0, 0, 0);

        for (int i = 0; i < tv.size(); i++) begin
            int s;
            @(negedge clk);
            s = tv[i].sel;
            vi = '0; hi = '0;
            for (int k = 0; k < 3; k++) di[k] = 8'h00;
            resetn = tv[i].r;
            vi[s] = tv[i].v;
            di[s] = tv[i].d;
            hi[s] = tv[i].h;
            #1;
            check($sformatf("vec%0d_sel%0d", i, s),
                  {rdy[s], dout_w[s], cen_w[s], done_w[s]},
                  {tv[i].er, tv[i].ed, tv[i].ec, tv[i].ew},
                  tv[i].dc ? 4'b1000 : 4'b1111);
        end

        // in_ready in IDLE must not follow in_valid
        @(negedge clk);
        vi = '0; hi = '0;
        #1;
        check("idle_ready_valid0", {rdy[0], 3'b000}, 4'b1000, 4'b1000);
        vi[0] = 1'b1; di[0] = 8'h3C;
        #1;
        check("idle_ready_valid1", {rdy[0], 3'b000}, 4'b1000, 4'b1000);

        // bounded wait for word_done with in_data scrambled after the transfer
        done_at = 0;
        for (int k = 1; k <= 20 && done_at == 0; k++) begin
            @(negedge clk);
            vi[0] = 1'b0;
            di[0] = 8'hC3;
            #1;
            if (done_w[0]) done_at = k;
        end
        checks++;
        if (done_at != 8) begin
            errors++;
            $display("FAIL done_latency got=%0d expected=8", done_at);
        end
        check("done_last_bit", {1'b0, dout_w[0], cen_w[0], 1'b0}, 4'b0010, 4'b0110);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
